// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial-pattern detector with run-time overlap select and valid qualifier.
// Optional saturating match counter built only when SEQDET_COUNT_EN is defined.
module moore_seq_detector_param #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1001,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_valid,
  input  logic             data,
  input  logic             overlap_en,
  input  logic             clear,
  output logic             detected,
  output logic [CNT_W-1:0] match_count,
  output logic [4:0]       state
);

  if (PAT_W < 2 || PAT_W > 16) begin : g_bad_pat_w
    $error("moore_seq_detector_param: PAT_W must be in 2..16");
  end

  localparam logic [4:0] S_IDLE  = 5'd0;
  localparam logic [4:0] S_MATCH = 5'(PAT_W);

  // Next-state table indexed by {state, bit}; fixed 64 entries so the index is exactly 6 bits.
  typedef logic [63:0][4:0] tbl_t;

  // Longest pattern prefix that is a suffix of (prefix k + b), evaluated at elaboration.
  function automatic tbl_t build_tbl();
    tbl_t        t;
    logic [15:0] pv;
    int          best, p;
    logic        ok, sb;
    t  = '0;
    pv = 16'(PATTERN);
    for (int k = 0; k <= PAT_W; k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        for (int j = 1; j <= PAT_W; j++) begin
          ok = (j <= k + 1);
          for (int m = 0; m < j; m++) begin
            p  = k + 1 - j + m;
            sb = (p == k) ? (b == 1) : pv[4'(PAT_W - 1 - p)];
            if (pv[4'(PAT_W - 1 - m)] != sb) ok = 1'b0;
          end
          if (ok) best = j;
        end
        t[6'(2 * k + b)] = 5'(best);
      end
    end
    return t;
  endfunction

  localparam tbl_t NXT_TBL = build_tbl();

  logic [4:0] state_q, state_d;
  logic       hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    hit     = 1'b0;
    if (data_valid) begin
      // Non-overlapping mode restarts from S0 once the match state is left.
      if (state_q == S_MATCH && !overlap_en) state_d = NXT_TBL[{S_IDLE, data}];
      else                                   state_d = NXT_TBL[{state_q, data}];
      hit = (state_d == S_MATCH);
    end
  end

  assign state    = state_q;
  assign detected = (state_q == S_MATCH);

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt_q <= '0;
    else if (clear)              cnt_q <= '0;
    else if (hit && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt  = ^{clear, hit};
  assign match_count = '0;
`endif

endmodule
